// File: rtl/dpi_ctx_pkg.sv
// Shared types for the DPI context engine: FSM state encoding and drain length.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dpi_ctx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_COMMIT = 3'd4
    } ctx_state_e;

    // One cycle for the outbound byte register plus one for the inbound
    // state/accept register, so the last byte's result is seen before commit.
    localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/dpi_ctx_ram.sv
// Per-stream DFA state store: 2**AW x DW, one write port, one registered read port.
// Latency: read data valid 1 cycle after address; write visible on the next cycle.
// Backpressure: none; always accepts a read and a write every cycle.
module dpi_ctx_ram #(
    parameter int AW = 6,
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_dat,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_dat
);

    // Contents are qualified by the engine's valid bits, so no reset here.
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rd_dat;

    // Write port and synchronous read port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        r_rd_dat <= r_mem[i_rd_addr];
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/dpi_ctx_engine.sv
// Per-stream regex context engine: restores/saves external DFA state around each packet.
// Latency: byte to DFA 1 cycle; eop to commit DRAIN_CYCLES+1 cycles; commit to IDLE 1 cycle.
// Backpressure: none; sop/eop outside their legal state are dropped and flag proto_err.
module dpi_ctx_engine
    import dpi_ctx_pkg::*;
#(
    parameter int SID_W   = 6,
    parameter int STATE_W = 11,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sop,
    input  logic               eop,
    input  logic               enable,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               clear_all,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_in_vld,
    input  logic [STATE_W-1:0] dfa_state_out,
    input  logic               dfa_accept,
    output logic [CNT_W-1:0]   count,
    output logic               fired,
    output logic               busy,
    output logic               proto_err
);

    localparam int         NSTREAM    = 2**SID_W;
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    ctx_state_e         r_state;
    ctx_state_e         w_next;
    logic [SID_W-1:0]   r_sid;
    logic               r_en;
    logic               r_new;
    logic [1:0]         r_drain_cnt;
    logic [7:0]         r_char;
    logic               r_char_vld;
    logic [STATE_W-1:0] r_dfa_state;
    logic               r_acc;
    logic [NSTREAM-1:0] r_ctx_valid;
    logic [CNT_W-1:0]   r_count;
    logic               r_fired;
    logic               r_perr;
    logic [SID_W-1:0]   w_rd_addr;
    logic [STATE_W-1:0] w_rd_dat;
    logic               w_sop_take;
    logic               w_commit_wr;
    logic               w_load_zero;

    assign w_sop_take  = (r_state == ST_IDLE) && sop;
    assign w_commit_wr = (r_state == ST_COMMIT) && r_en;
    assign w_load_zero = r_new || !r_ctx_valid[r_sid];
    // Address the RAM with the incoming id while idle so data is ready in LOAD.
    assign w_rd_addr   = (r_state == ST_IDLE) ? stream_id : r_sid;

    dpi_ctx_ram #(
        .AW (SID_W),
        .DW (STATE_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_commit_wr),
        .i_wr_addr (r_sid),
        .i_wr_dat  (r_dfa_state),
        .i_rd_addr (w_rd_addr),
        .o_rd_dat  (w_rd_dat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next           = r_state;
        busy             = (r_state != ST_IDLE);
        dfa_state_in_vld = 1'b0;
        case (r_state)
            ST_IDLE:   if (sop) w_next = ST_LOAD;
            ST_LOAD: begin
                dfa_state_in_vld = 1'b1;
                w_next           = ST_RUN;
            end
            ST_RUN:    if (eop) w_next = ST_DRAIN;
            ST_DRAIN:  if (r_drain_cnt == DRAIN_LAST) w_next = ST_COMMIT;
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign dfa_state_in = (r_state == ST_LOAD && !w_load_zero) ? w_rd_dat : '0;

    // Capture per-packet controls when a packet is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sid <= '0;
            r_en  <= 1'b0;
            r_new <= 1'b0;
        end else if (w_sop_take) begin
            r_sid <= stream_id;
            r_en  <= enable;
            r_new <= new_stream_id;
        end
    end

    // Drain cycle counter, restarts whenever not draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_drain_cnt <= 2'd0;
        else if (r_state != ST_DRAIN) r_drain_cnt <= 2'd0;
        else                          r_drain_cnt <= r_drain_cnt + 2'd1;
    end

    // Outbound byte register (bytes outside RUN are dropped) and inbound DFA result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char      <= '0;
            r_char_vld  <= 1'b0;
            r_dfa_state <= '0;
            r_acc       <= 1'b0;
        end else begin
            r_char      <= char_in;
            r_char_vld  <= (r_state == ST_RUN) && char_in_vld;
            r_dfa_state <= dfa_state_out;
            r_acc       <= dfa_accept;
        end
    end

    assign dfa_char     = r_char;
    assign dfa_char_vld = r_char_vld;

    // Context valid bits: clear_all wipes everything, a commit on the same cycle re-sets its bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctx_valid <= '0;
        end else begin
            if (clear_all)   r_ctx_valid        <= '0;
            if (w_commit_wr) r_ctx_valid[r_sid] <= 1'b1;
        end
    end

    // Saturating matched-packet counter, updated at commit of an enabled packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_commit_wr && r_fired && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Per-packet match flag: cleared on packet start or disabled commit, set by accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fired <= 1'b0;
        end else if (w_sop_take || (r_state == ST_COMMIT && !r_en)) begin
            r_fired <= 1'b0;
        end else if ((r_state == ST_RUN || r_state == ST_DRAIN) && r_acc) begin
            r_fired <= 1'b1;
        end
    end

    // Sticky protocol error for sop outside IDLE or eop outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else if ((sop && r_state != ST_IDLE) || (eop && r_state != ST_RUN)) begin
            r_perr <= 1'b1;
        end
    end

    assign count     = r_count;
    assign fired     = r_fired;
    assign proto_err = r_perr;

endmodule
